// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM driving ALU, memory, register file and PC strobes
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        alu_flag,
  input  logic        mem_waitrequest,
  input  logic        pc_zero,
  output logic [4:0]  ALUControl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        active,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;
  localparam logic [4:0] AND_OP = 5'b00000, OR_OP = 5'b00001, ADD_OP = 5'b00010, XOR_OP = 5'b00011,
                         SLL_OP = 5'b00100, SRL_OP = 5'b00101, SUBU_OP = 5'b00110, SLT_OP = 5'b00111,
                         SRA_OP = 5'b01000, SLTU_OP = 5'b01001, EQ_OP = 5'b01010, JADD_OP = 5'b01101,
                         PASS_OP = 5'b01110;
  state_t state;
  logic [5:0] op, fn;
  logic [4:0] r_op, i_op;
  logic r_ok, i_alu, is_r, is_jr, is_lw, is_sw, is_br, is_j, is_jal, ok;
  logic unused_fields;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];
  assign is_r = op == 6'h00;
  assign is_jr = is_r && fn == 6'h08;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2B;
  assign is_br = op == 6'h04 || op == 6'h05;
  assign is_j = op == 6'h02;
  assign is_jal = op == 6'h03;
  assign ok = (is_r && (r_ok || is_jr)) || i_alu || is_lw || is_sw || is_br || is_j || is_jal;
  // ALU operation selected by R-type funct and by I-type ALU opcode
  always_comb begin
    r_ok = is_r;
    r_op = ADD_OP;
    case (fn)
      6'h21: r_op = ADD_OP;
      6'h23: r_op = SUBU_OP;
      6'h24: r_op = AND_OP;
      6'h25: r_op = OR_OP;
      6'h26: r_op = XOR_OP;
      6'h00: r_op = SLL_OP;
      6'h02: r_op = SRL_OP;
      6'h03: r_op = SRA_OP;
      6'h2A: r_op = SLT_OP;
      6'h2B: r_op = SLTU_OP;
      default: r_ok = 1'b0;
    endcase
    i_alu = 1'b1;
    i_op = ADD_OP;
    case (op)
      6'h09: i_op = ADD_OP;
      6'h0A: i_op = SLT_OP;
      6'h0B: i_op = SLTU_OP;
      6'h0C: i_op = AND_OP;
      6'h0D: i_op = OR_OP;
      6'h0E: i_op = XOR_OP;
      default: i_alu = 1'b0;
    endcase
  end
  // state sequencing; HALT and FAULT are left only through reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   state <= pc_zero ? HALT : mem_waitrequest ? FETCH : DECODE;
        DECODE:  state <= ok ? EXEC : FAULT;
        EXEC:    state <= (is_lw || is_sw) ? MEM : (r_ok || i_alu || is_jal) ? WB : FETCH;
        MEM:     state <= mem_waitrequest ? MEM : is_lw ? WB : FETCH;
        WB:      state <= FETCH;
        default: state <= state;
      endcase
  // control outputs decoded from state so reset drops every strobe at once
  always_comb begin
    ALUControl = AND_OP;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    imm_zext = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'b00;
    reg_write = 1'b0;
    reg_dst = 2'b00;
    mem_to_reg = 1'b0;
    active = 1'b0;
    fault = 1'b0;
    case (state)
      FETCH: begin
        active = 1'b1;
        mem_read = !pc_zero;
        if (!pc_zero && !mem_waitrequest) begin
          ir_write = 1'b1;
          ALUControl = ADD_OP;
          alu_src_b = 2'b01;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        active = 1'b1;
        ALUControl = JADD_OP;
        alu_src_b = 2'b11;
      end
      EXEC: begin
        active = 1'b1;
        if (r_ok) begin
          ALUControl = r_op;
          alu_src_a = 1'b1;
        end else if (i_alu) begin
          ALUControl = i_op;
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          imm_zext = op[5:2] == 4'b0011;
        end else if (is_lw || is_sw) begin
          ALUControl = ADD_OP;
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end else if (is_br) begin
          ALUControl = EQ_OP;
          alu_src_a = 1'b1;
          pc_src = 2'b01;
          pc_write = alu_flag ^ op[0];
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src = 2'b10;
        end else if (is_jr) begin
          ALUControl = PASS_OP;
          alu_src_a = 1'b1;
          pc_write = 1'b1;
        end
      end
      MEM: begin
        active = 1'b1;
        iord = 1'b1;
        mem_read = is_lw;
        mem_write = is_sw;
      end
      WB: begin
        active = 1'b1;
        reg_write = 1'b1;
        reg_dst = is_r ? 2'b01 : is_jal ? 2'b10 : 2'b00;
        mem_to_reg = is_lw;
        ALUControl = is_jal ? PASS_OP : AND_OP;
      end
      FAULT: fault = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the multicycle control sequence
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, alu_flag = 1'b0, mem_waitrequest = 1'b0, pc_zero = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [4:0] ALUControl;
  logic alu_src_a, imm_zext, iord, mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg, active, fault;
  logic [1:0] alu_src_b, pc_src, reg_dst;
  logic [21:0] ctl;
  int checks = 0, failures = 0;
  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .alu_flag(alu_flag),
    .mem_waitrequest(mem_waitrequest), .pc_zero(pc_zero), .ALUControl(ALUControl),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .active(active), .fault(fault)
  );
  assign ctl = {ALUControl, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write, ir_write,
                pc_write, pc_src, reg_write, reg_dst, mem_to_reg, active, fault};
  always #5 clk = ~clk;
  function automatic logic [21:0] v(input logic [4:0] alu, input logic sa, input logic [1:0] sb,
    input logic zx, input logic io, input logic mr, input logic mw, input logic irw, input logic pcw,
    input logic [1:0] pcs, input logic rw, input logic [1:0] rd, input logic m2r, input logic act,
    input logic flt);
    return {alu, sa, sb, zx, io, mr, mw, irw, pcw, pcs, rw, rd, m2r, act, flt};
  endfunction
  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  logic [21:0] zero_v, fetch_v, fwait_v, decode_v, halt_v;
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    zero_v   = '0;
    fetch_v  = v(5'd2, 0, 2'b01, 0, 0, 1, 0, 1, 1, 2'b00, 0, 2'b00, 0, 1, 0);
    fwait_v  = v(5'd0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0);
    decode_v = v(5'd13, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0);
    halt_v   = zero_v;
    instr = 32'h00851021;
    #12;
    chk("reset", ctl, zero_v);
    tick();
    chk("reset_clk", ctl, zero_v);
    reset_n = 1'b1;
    #1;
    chk("idle", ctl, zero_v);
    tick(); chk("addu_fetch", ctl, fetch_v);
    tick(); chk("addu_decode", ctl, decode_v);
    tick(); chk("addu_exec", ctl, v(5'd2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    tick(); chk("addu_wb", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 1, 0));
    tick(); chk("addu_refetch", ctl, fetch_v);
    instr = 32'h8C820004;
    mem_waitrequest = 1'b1;
    #1 chk("lw_fwait1", ctl, fwait_v);
    tick(); chk("lw_fwait2", ctl, fwait_v);
    tick(); chk("lw_fwait3", ctl, fwait_v);
    tick(); mem_waitrequest = 1'b0;
    #1 chk("lw_fetch", ctl, fetch_v);
    tick(); chk("lw_decode", ctl, decode_v);
    tick(); chk("lw_exec", ctl, v(5'd2, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    mem_waitrequest = 1'b1;
    tick(); chk("lw_mwait1", ctl, v(5'd0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    tick(); chk("lw_mwait2", ctl, v(5'd0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    mem_waitrequest = 1'b0;
    #1 chk("lw_mem", ctl, v(5'd0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    tick(); chk("lw_wb", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 1, 0));
    tick(); chk("lw_refetch", ctl, fetch_v);
    instr = 32'h34A20001;
    tick(); tick(); chk("ori_exec", ctl, v(5'd1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    tick(); chk("ori_wb", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 0));
    tick(); instr = 32'h10850003; alu_flag = 1'b1;
    tick(); tick(); chk("beq_taken", ctl, v(5'd10, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 1, 0));
    tick(); chk("beq_refetch", ctl, fetch_v);
    alu_flag = 1'b0;
    tick(); tick(); chk("beq_not", ctl, v(5'd10, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 1, 0));
    tick(); instr = 32'h14850003;
    tick(); tick(); chk("bne_taken", ctl, v(5'd10, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 1, 0));
    tick(); instr = 32'h0C000010;
    tick(); tick(); chk("jal_exec", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 1, 0));
    tick(); chk("jal_wb", ctl, v(5'd14, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 1, 0));
    tick(); chk("jal_refetch", ctl, fetch_v);
    instr = 32'h00000008;
    tick(); tick(); chk("jr_exec", ctl, v(5'd14, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 1, 0));
    pc_zero = 1'b1;
    tick(); chk("jr_fetch_nord", {21'd0, mem_read}, 22'd0);
    tick(); chk("halt", ctl, halt_v);
    tick(); chk("halt_stay", ctl, halt_v);
    reset_n = 1'b0;
    pc_zero = 1'b0;
    instr = 32'hFC000000;
    #1 reset_n = 1'b1;
    tick(); chk("bad_fetch", ctl, fetch_v);
    tick(); chk("bad_decode", ctl, decode_v);
    tick(); chk("fault", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));
    tick(); chk("fault_stay", ctl, v(5'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));
    reset_n = 1'b0;
    instr = 32'hAC820004;
    #1 chk("fault_reset", ctl, zero_v);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("sw_exec", ctl, v(5'd2, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    mem_waitrequest = 1'b1;
    tick(); chk("sw_mwait", ctl, v(5'd0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    #1 reset_n = 1'b0;
    #1 chk("sw_reset_drop", ctl, zero_v);
    mem_waitrequest = 1'b0;
    tick(); chk("sw_reset_hold", ctl, zero_v);
    reset_n = 1'b1;
    #1 chk("sw_idle", ctl, zero_v);
    tick(); chk("sw_restart", ctl, fetch_v);
    tick(); tick(); tick(); chk("sw_mem", ctl, v(5'd0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));
    tick(); chk("sw_refetch", ctl, fetch_v);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
